// File: rtl/latch_seq_pkg.sv
// Shared types and constants for the latch bank write sequencer.
// Holds the FSM encoding, the index-width helper and the strobe counter width.
package latch_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int unsigned clog2_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Strobe counter width; covers STROBE_CYC up to 256.
  localparam int unsigned STROBE_CNT_W = 8;

endpackage

// File: rtl/latch_bank_seq_if.sv
// Requester and latch-bank signal bundle for latch_bank_seq.
// The master side drives requests; the slave side is the sequencer.
interface latch_bank_seq_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
);

  localparam int unsigned IW = latch_seq_pkg::clog2_w(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*W-1:0]  wdata;
  logic [NREQ-1:0]    ack;
  logic [W-1:0]       d;
  logic [DEPTH-1:0]   e;
  logic               busy;
  logic [IW-1:0]      gnt_id;

  modport master (
    output req, addr, wdata,
    input  ack, d, e, busy, gnt_id
  );

  modport slave (
    input  req, addr, wdata,
    output ack, d, e, busy, gnt_id
  );

endinterface

// File: rtl/latch_bank_seq_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first active request
// found after the last-granted index, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   gnt,
  output logic            valid
);

  logic [IW-1:0] idx;

  // Scan last+1 .. last+NREQ; the previous winner is checked last.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IW'((32'(last) + k) % NREQ);
      if (!valid && req[idx]) begin
        valid = 1'b1;
        gnt   = idx;
      end
    end
  end

endmodule

// File: rtl/latch_bank_seq.sv
// Write sequencer for a bank of level-sensitive latch words: arbitrates
// requesters and drives d / one-hot e with a setup, strobe, hold sequence.
module latch_bank_seq
  import latch_seq_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned W          = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AW         = 2,
  parameter int unsigned STROBE_CYC = 2
) (
  input logic              clk,
  input logic              rst,
  latch_bank_seq_if.slave  bus
);

  localparam int unsigned IW = clog2_w(NREQ);
  localparam int unsigned CW = STROBE_CNT_W;

  state_t           state_q, state_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [AW-1:0]    addr_q, addr_n;
  logic [W-1:0]     d_q, d_n;
  logic [DEPTH-1:0] e_q, e_n;
  logic [NREQ-1:0]  ack_q, ack_n;
  logic             busy_q, busy_n;
  logic [IW-1:0]    gnt_q, gnt_n;
  logic [IW-1:0]    last_q, last_n;

  logic [IW-1:0]    arb_gnt;
  logic             arb_valid;
  logic [AW-1:0]    sel_addr;
  logic [W-1:0]     sel_data;
  logic [DEPTH-1:0] strobe_vec;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req   (bus.req),
    .last  (last_q),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  // Winner's address/data slices and the enable pattern for the captured address.
  always_comb begin
    sel_addr   = bus.addr[int'(arb_gnt)*AW +: AW];
    sel_data   = bus.wdata[int'(arb_gnt)*W +: W];
    strobe_vec = DEPTH'(1) << addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      d_q     <= '0;
      e_q     <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      gnt_q   <= '0;
      last_q  <= IW'(NREQ - 1);
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      addr_q  <= addr_n;
      d_q     <= d_n;
      e_q     <= e_n;
      ack_q   <= ack_n;
      busy_q  <= busy_n;
      gnt_q   <= gnt_n;
      last_q  <= last_n;
    end
  end

  // Outputs are computed for the state being entered, so they register with it.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    addr_n  = addr_q;
    d_n     = d_q;
    e_n     = '0;
    ack_n   = '0;
    gnt_n   = gnt_q;
    last_n  = last_q;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_n = SETUP;
          addr_n  = sel_addr;
          d_n     = sel_data;
          gnt_n   = arb_gnt;
          last_n  = arb_gnt;
        end
      end
      SETUP: begin
        state_n = STROBE;
        cnt_n   = CW'(STROBE_CYC - 1);
        e_n     = strobe_vec;
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_n       = HOLD;
          ack_n[gnt_q]  = 1'b1;
        end else begin
          cnt_n = cnt_q - CW'(1);
          e_n   = strobe_vec;
        end
      end
      HOLD: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  assign bus.d      = d_q;
  assign bus.e      = e_q;
  assign bus.ack    = ack_q;
  assign bus.busy   = busy_q;
  assign bus.gnt_id = gnt_q;

endmodule

// File: tb/tb_latch_bank_seq.sv
// Self-checking bench for latch_bank_seq: directed timing checks plus a
// scoreboard of expected writes matched against each observed ack.
module tb_latch_bank_seq;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned SC    = 2;

  typedef struct {
    int id;
    int a;
    int data;
  } txn_t;

  logic clk;
  logic rst;
  bit   drop_on_ack;
  int   n_chk;
  int   n_pass;
  txn_t exp_q[$];

  latch_bank_seq_if #(.NREQ(NREQ), .W(W), .DEPTH(DEPTH), .AW(AW)) bus ();

  latch_bank_seq #(
    .NREQ(NREQ), .W(W), .DEPTH(DEPTH), .AW(AW), .STROBE_CYC(SC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic push_exp(input int id, input int a, input int data);
    txn_t t;
    t.id = id;
    t.a = a;
    t.data = data;
    exp_q.push_back(t);
  endtask

  task automatic set_req(input int i, input int a, input int data);
    bus.addr[i*AW +: AW] = AW'(a);
    bus.wdata[i*W +: W]  = W'(data);
    bus.req[i]           = 1'b1;
  endtask

  int  cyc;
  bit  prev_busy;

  // One clock: sample ack/busy before the edge, act #1 after it.
  task automatic tick();
    logic [NREQ-1:0] a;
    @(negedge clk);
    a = bus.ack;
    prev_busy = bus.busy;
    @(posedge clk);
    #1;
    cyc++;
    if (drop_on_ack) bus.req = bus.req & ~a;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant(output int at, output bit ok);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (bus.busy && !prev_busy) begin
        ok = 1'b1;
        at = cyc;
      end
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_d"}, 32'(bus.d), 32'h0);
    chk({tag, "_e"}, 32'(bus.e), 32'h0);
    chk({tag, "_ack"}, 32'(bus.ack), 32'h0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
    chk({tag, "_gnt"}, 32'(bus.gnt_id), 32'h0);
  endtask

  // Monitor: collects each write as seen on the bank side and scores it at ack.
  bit               in_txn;
  int               m_id;
  int               m_e_cnt;
  logic [DEPTH-1:0] m_e_val;
  logic [W-1:0]     m_d;

  always @(negedge clk) begin : monitor
    txn_t t;
    if (rst) begin
      in_txn = 1'b0;
    end else begin
      chk("e_popcount", 32'($countones(bus.e) <= 1), 32'h1);
      chk("e_outside_busy", 32'((bus.e != '0) && !bus.busy), 32'h0);
      if (bus.busy && !in_txn) begin
        in_txn  = 1'b1;
        m_id    = int'(bus.gnt_id);
        m_d     = bus.d;
        m_e_cnt = 0;
        m_e_val = '0;
      end
      if (in_txn && bus.e != '0) begin
        m_e_cnt++;
        m_e_val = bus.e;
        chk("d_stable_strobe", 32'(bus.d), 32'(m_d));
      end
      if (bus.ack != '0) begin
        chk("ack_onehot", 32'(bus.ack), 32'(1) << m_id);
        chk("e_in_hold", 32'(bus.e), 32'h0);
        chk("d_in_hold", 32'(bus.d), 32'(m_d));
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 32'(bus.ack), 32'h0);
        end else begin
          t = exp_q.pop_front();
          chk("sb_id", 32'(m_id), 32'(t.id));
          chk("sb_strobe_bit", 32'(m_e_val), 32'(1) << t.a);
          chk("sb_data", 32'(m_d), 32'(t.data));
          chk("sb_strobe_len", 32'(m_e_cnt), 32'(SC));
        end
        in_txn = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int at;
    int prev_at;
    int prev_g;
    bit ok;
    n_chk = 0;
    n_pass = 0;
    cyc = 0;
    drop_on_ack = 1'b0;
    rst = 1'b1;
    bus.req = '0;
    bus.addr = '0;
    bus.wdata = '0;

    // Reset with random requests present
    repeat (3) begin
      bus.req = NREQ'($urandom);
      tick();
      chk_idle_outs("reset");
    end
    bus.req = '0;
    rst = 1'b0;
    tick();
    chk_idle_outs("post_reset");

    // Single write timing
    drop_on_ack = 1'b1;
    set_req(0, 2, 'hA5);
    push_exp(0, 2, 'hA5);
    tick();
    chk("single_setup_d", 32'(bus.d), 32'hA5);
    chk("single_setup_e", 32'(bus.e), 32'h0);
    chk("single_setup_busy", 32'(bus.busy), 32'h1);
    tick();
    chk("single_strobe1_e", 32'(bus.e), 32'h4);
    tick();
    chk("single_strobe2_e", 32'(bus.e), 32'h4);
    tick();
    chk("single_hold_e", 32'(bus.e), 32'h0);
    chk("single_hold_d", 32'(bus.d), 32'hA5);
    chk("single_hold_ack", 32'(bus.ack), 32'h1);
    tick();
    chk("single_idle_busy", 32'(bus.busy), 32'h0);
    chk("single_idle_ack", 32'(bus.ack), 32'h0);
    chk("single_idle_d", 32'(bus.d), 32'hA5);
    repeat (2) tick();

    // Contention: all requesters held from reset
    drop_on_ack = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, i, 'h10 + i);
    do_reset();
    for (int k = 0; k < 5; k++) push_exp(k % NREQ, k % NREQ, 'h10 + (k % NREQ));
    prev_at = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant(at, ok);
      chk("contend_grant_seen", 32'(ok), 32'h1);
      chk("contend_gnt", 32'(bus.gnt_id), 32'(k % NREQ));
      if (k > 0) chk("contend_spacing", 32'(at - prev_at), 32'(SC + 3));
      prev_at = at;
    end
    bus.req = '0;
    repeat (8) tick();

    // Fairness between requesters 1 and 3
    set_req(1, 3, 'h21);
    set_req(3, 1, 'h23);
    do_reset();
    prev_g = -1;
    for (int k = 0; k < 4; k++) push_exp((k % 2 == 0) ? 1 : 3, (k % 2 == 0) ? 3 : 1,
                                         (k % 2 == 0) ? 'h21 : 'h23);
    for (int k = 0; k < 4; k++) begin
      wait_grant(at, ok);
      chk("fair_grant_seen", 32'(ok), 32'h1);
      chk("fair_gnt", 32'(bus.gnt_id), (k % 2 == 0) ? 32'd1 : 32'd3);
      chk("fair_no_repeat", 32'(int'(bus.gnt_id) == prev_g), 32'h0);
      prev_g = int'(bus.gnt_id);
    end
    bus.req = '0;
    repeat (8) tick();

    // Abort in first strobe cycle
    set_req(2, 3, 'h5A);
    do_reset();
    tick();
    chk("abort_gnt", 32'(bus.gnt_id), 32'h2);
    tick();
    chk("abort_strobe_e", 32'(bus.e), 32'h8);
    rst = 1'b1;
    set_req(0, 1, 'h77);
    tick();
    chk("abort_e", 32'(bus.e), 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_ack", 32'(bus.ack), 32'h0);
    rst = 1'b0;
    drop_on_ack = 1'b1;
    push_exp(0, 1, 'h77);
    push_exp(2, 3, 'h5A);
    tick();
    chk("abort_regrant", 32'(bus.gnt_id), 32'h0);
    chk("abort_regrant_busy", 32'(bus.busy), 32'h1);
    repeat (12) tick();
    chk("abort_drained", 32'(bus.req), 32'h0);

    // Early drop during SETUP
    set_req(2, 1, 'h3C);
    push_exp(2, 1, 'h3C);
    tick();
    chk("drop_gnt", 32'(bus.gnt_id), 32'h2);
    bus.req[2] = 1'b0;
    bus.addr[2*AW +: AW] = AW'(3);
    bus.wdata[2*W +: W]  = W'('hFF);
    tick();
    chk("drop_strobe_e", 32'(bus.e), 32'h2);
    chk("drop_strobe_d", 32'(bus.d), 32'h3C);
    repeat (8) tick();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/latch_bank_seq.md
Name: latch_bank_seq

Overview:
- Sequences writes into a shared bank of DEPTH level-sensitive D-latch words, each built from the team's NAND D-latch cell (enable e, data d).
- Arbitrates round-robin among NREQ requesters.
- Drives the bank's d bus and one-hot e strobes with a fixed setup/strobe/hold sequence, so d is stable before e rises and after e falls.
- Sits between requesting logic and the latch bank; the bank itself is outside this block.

Parameters:
NREQ, 4, number of requesters (>=2)
W, 8, data width of each latch word
DEPTH, 4, number of latch words in the bank
AW, 2, address width, equal to clog2(DEPTH)
STROBE_CYC, 2, cycles e is held high per write (>=1)

Ports:
clk  input  1  single clock; all state changes on its rising edge
rst  input  1  synchronous, active-high reset
req  input  NREQ  per-requester write request; held high until the edge at which its ack is high
addr  input  NREQ*AW  packed word addresses, requester i at [i*AW +: AW]
wdata  input  NREQ*W  packed write data, requester i at [i*W +: W]
ack  output  NREQ  one-cycle completion pulse per requester
d  output  W  data bus to the latch bank
e  output  DEPTH  one-hot (or zero) latch enables
busy  output  1  high in every state except IDLE
gnt_id  output  clog2(NREQ)  index of the current or last granted requester

Behaviour:
- All outputs are registered.
- Reset (rst=1 at an edge):
  - state=IDLE; d=0, e=0, ack=0, busy=0, gnt_id=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has top priority first.
- Reset mid-transaction: e drops to 0 on the next edge. No ack is issued for the aborted write. The latch word content is undefined and is not retried.
- States: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
- IDLE, edge with any req high:
  - Grant the first requester with req high, searching last+1, last+2, ... (mod NREQ).
  - Capture its addr and wdata into internal registers; set gnt_id and last to that index.
  - Next state SETUP; busy=1.
  - With no req high, stay in IDLE and keep all outputs stable, d included.
- SETUP (1 cycle): d=captured data, e=0.
- STROBE (exactly STROBE_CYC cycles): e[captured addr]=1, all other e bits 0, d unchanged.
- HOLD (1 cycle): e=0, d unchanged, ack[gnt_id]=1.
- Next IDLE: ack=0, busy=0. d keeps its last value until the next SETUP.
- Latency: req sampled at edge T gives SETUP at T+1, e high T+2..T+1+STROBE_CYC, HOLD/ack at T+2+STROBE_CYC, IDLE at T+3+STROBE_CYC.
- Transaction length: STROBE_CYC+3 cycles, IDLE arbitration cycle included.
- Back-to-back: a requester that keeps req high across its ack edge is treated as making a new request and is re-arbitrated in the following IDLE at lowest priority.
- req, addr and wdata are ignored outside IDLE. Dropping req mid-transaction does not cancel it; the write completes and ack still pulses.
- Simultaneous requests are resolved purely by the round-robin order; no requester waits more than NREQ-1 transactions.
- Invariants:
  - e has popcount <= 1 at all times.
  - e is never high in SETUP, HOLD or IDLE.
  - At most one ack bit is high, and only in HOLD.
- Address >= DEPTH (when DEPTH is not a power of 2): the sequence runs fully with e=0 throughout and ack is still issued.

Decomposition:
- Package latch_seq_pkg holds:
  - state enum: IDLE, SETUP, STROBE, HOLD (2-bit encoding);
  - helper function for the clog2 width;
  - strobe counter width constant.
- One sub-module, rr_arbiter: NREQ-wide req, last-grant pointer in, grant index and valid out; purely combinational.
- Pointer update and all sequencing stay in latch_bank_seq.

Test Plan:
- Reset: hold rst=1 for 3 cycles with random req -> d=0, e=0, ack=0, busy=0, gnt_id=0 throughout and on the first cycle after release.
- Single write, STROBE_CYC=2, req0=1, addr0=2, wdata0=0xA5 sampled at T:
  - T+1: d=0xA5, e=0000.
  - T+2 and T+3: e=0100.
  - T+4: e=0000, d=0xA5, ack=0001.
  - T+5: busy=0.
- Contention: req=1111 held continuously from reset -> grants in order 0,1,2,3,0, spaced 5 cycles; each ack goes to the matching requester; e is always one-hot or zero.
- Fairness: req1 and req3 held continuously -> gnt_id alternates 1,3,1,3; neither is granted twice in a row.
- Abort: rst=1 in the first STROBE cycle -> e=0 and busy=0 at the next edge, no ack pulse, and the next grant after release goes to requester 0 if it is requesting.
- Early drop: req2 deasserted during SETUP -> STROBE and HOLD still run for addr2/wdata2, and ack[2] pulses once.
